// File: rtl/rs_encoder.sv
// Systematic RS(255,223) encoder over GF(2^8).
// Message symbols pass straight through to a registered output while a
// 32-stage LFSR divides by the generator polynomial. The 32 remainder
// symbols are then shifted out as parity, highest degree first.
module rs_encoder #(
   parameter int         M         = 8,
   parameter int         N         = 255,
   parameter int         K         = 223,
   parameter logic [M:0] PRIM_POLY = 9'h11D,
   parameter int         FCR       = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [M-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [M-1:0] out_data,
   output logic         out_sop,
   output logic         out_eop,
   output logic         busy
);

   localparam int NPAR = N - K;
   localparam int CNTW = $clog2(K + 1);
   localparam logic [M-1:0]    GF_ONE    = {{(M-1){1'b0}}, 1'b1};
   localparam logic [M-1:0]    GF_ALPHA  = {{(M-2){1'b0}}, 2'b10};
   localparam logic [CNTW-1:0] CNT_ONE   = {{(CNTW-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0] CNT_LASTM = CNTW'(K - 1);
   localparam logic [CNTW-1:0] CNT_LASTP = CNTW'(NPAR - 1);

   // GF(2^M) multiply; with one operand constant it reduces to an XOR network.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] p;
      logic [M-1:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < M; i++) begin
         if (b[i]) p = p ^ x;
         else      p = p;
         if (x[M-1]) x = (x << 1) ^ PRIM_POLY[M-1:0];
         else        x = x << 1;
      end
      return p;
   endfunction

   // Generator prod_j (x + alpha^(FCR+j)); returns coefficients 0..NPAR-1 (monic term dropped).
   function automatic logic [NPAR*M-1:0] gen_poly();
      logic [(NPAR+1)*M-1:0] c;
      logic [M-1:0]          root;
      c        = '0;
      c[0 +: M] = GF_ONE;
      root     = GF_ONE;
      for (int k = 0; k < FCR; k++) root = gf_mul(root, GF_ALPHA);
      for (int j = 0; j < NPAR; j++) begin
         for (int i = NPAR; i >= 1; i--)
            c[i*M +: M] = c[(i-1)*M +: M] ^ gf_mul(c[i*M +: M], root);
         c[0 +: M] = gf_mul(c[0 +: M], root);
         root      = gf_mul(root, GF_ALPHA);
      end
      return c[NPAR*M-1:0];
   endfunction

   localparam logic [NPAR*M-1:0] GEN = gen_poly();

   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2} state_t;

   state_t             state_r;
   logic [NPAR*M-1:0]  par_r;
   logic [CNTW-1:0]    sym_cnt_r;
   logic               adv_s;
   logic               acc_s;
   logic [M-1:0]       fb_s;
   logic [NPAR*M-1:0]  par_upd_s;
   logic [NPAR*M-1:0]  par_shift_s;

   assign adv_s    = out_ready | ~out_valid;
   assign in_ready = adv_s & ((state_r == IDLE) | (state_r == DATA));
   assign acc_s    = in_valid & in_ready;
   assign busy     = (state_r != IDLE);

   // Next LFSR contents for a message symbol and for a parity shift-out.
   always_comb begin
      fb_s      = in_data ^ par_r[(NPAR-1)*M +: M];
      par_upd_s = '0;
      par_upd_s[0 +: M] = gf_mul(fb_s, GEN[0 +: M]);
      for (int i = 1; i < NPAR; i++)
         par_upd_s[i*M +: M] = par_r[(i-1)*M +: M] ^ gf_mul(fb_s, GEN[i*M +: M]);
      par_shift_s = {par_r[(NPAR-1)*M-1:0], {M{1'b0}}};
   end

   // Codeword sequencer, LFSR and registered output stage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         par_r     <= '0;
         sym_cnt_r <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
      end else if (adv_s) begin
         case (state_r)
            IDLE: begin
               if (acc_s) begin
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  out_sop   <= 1'b1;
                  out_eop   <= 1'b0;
                  par_r     <= par_upd_s;
                  sym_cnt_r <= CNT_ONE;
                  state_r   <= DATA;
               end else begin
                  out_valid <= 1'b0;
               end
            end
            DATA: begin
               if (acc_s) begin
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  out_sop   <= 1'b0;
                  out_eop   <= 1'b0;
                  par_r     <= par_upd_s;
                  if (sym_cnt_r == CNT_LASTM) begin
                     sym_cnt_r <= '0;
                     state_r   <= PARITY;
                  end else begin
                     sym_cnt_r <= sym_cnt_r + CNT_ONE;
                  end
               end else begin
                  out_valid <= 1'b0;
               end
            end
            PARITY: begin
               // Shifting zeros in leaves par cleared once the last parity symbol leaves.
               out_data  <= par_r[(NPAR-1)*M +: M];
               out_valid <= 1'b1;
               out_sop   <= 1'b0;
               par_r     <= par_shift_s;
               if (sym_cnt_r == CNT_LASTP) begin
                  out_eop   <= 1'b1;
                  sym_cnt_r <= '0;
                  state_r   <= IDLE;
               end else begin
                  out_eop   <= 1'b0;
                  sym_cnt_r <= sym_cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r   <= IDLE;
               par_r     <= '0;
               sym_cnt_r <= '0;
               out_valid <= 1'b0;
            end
         endcase
      end else begin
         state_r <= state_r;
      end
   end

endmodule

// File: tb/tb_rs_encoder.sv
// Directed bench for rs_encoder: table of message scenarios plus
// back-to-back and reset-in-parity sequences. Correctness is judged by
// message passthrough, framing flags, hand-computed parity values and
// syndromes S1..S32 evaluated on the captured codeword.
module tb_rs_encoder;

   localparam int K  = 223;
   localparam int N  = 255;
   localparam int NP = 32;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic       out_sop;
   logic       out_eop;
   logic       busy;

   rs_encoder dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sop(out_sop), .out_eop(out_eop), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc_g = 0;
   always @(posedge clk) cyc_g <= cyc_g + 1;

   typedef struct {
      int         kind;      // 0 all-zero, 1 impulse at symbol 222, 2 random
      logic [7:0] val;       // impulse value
      int         rp;        // out_ready percentage
      int         vp;        // in_valid percentage
      logic       chk_last;  // compare codeword symbol 254
      logic [7:0] exp_last;  // hand-computed val * alpha^18 (g[0] = alpha^(1+..+32))
      logic       cmp_gold;  // compare with the earlier full-rate random run
   } vec_t;

   vec_t       vecs [5];
   logic [7:0] msg  [0:2*K-1];
   logic [7:0] rnd  [0:K-1];
   logic [7:0] gold [0:N-1];
   logic [7:0] cap  [0:2*N-1];
   logic       cap_sop [0:2*N-1];
   logic       cap_eop [0:2*N-1];
   int         cap_cyc [0:2*N-1];
   int         checks = 0;
   int         failures = 0;
   int         stall_bad;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] gf_pow(input int e);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < e; i++) r = gf_mul(r, 8'h02);
      return r;
   endfunction

   // r(alpha^j), first captured symbol being the highest-degree coefficient.
   function automatic logic [7:0] synd(input int base, input int j);
      logic [7:0] a;
      logic [7:0] s;
      a = gf_pow(j);
      s = 8'h00;
      for (int i = 0; i < N; i++) s = gf_mul(s, a) ^ cap[base + i];
      return s;
   endfunction

   // Drive ncw codewords from msg[] and capture outputs; stops early when
   // abort_at output symbols have been taken (abort_at < 0: never).
   task automatic run_cw(input int rp, input int vp, input int ncw, input int abort_at);
      int ni, no, cyc, total_in, total_out;
      logic       held;
      logic [7:0] held_d;
      ni = 0; no = 0; cyc = 0; held = 1'b0; held_d = 8'h00;
      total_in = ncw * K; total_out = ncw * N; stall_bad = 0;
      while (no < total_out && cyc < 8000) begin
         if (abort_at >= 0 && no == abort_at) break;
         in_valid  = (ni < total_in) && ($urandom_range(1, 100) <= vp);
         in_data   = in_valid ? msg[ni] : 8'($urandom_range(0, 255));
         out_ready = ($urandom_range(1, 100) <= rp);
         @(negedge clk);
         if (in_valid && in_ready) ni++;
         if (out_valid) begin
            if (held && out_data != held_d) stall_bad++;
            held   = ~out_ready;
            held_d = out_data;
            if (out_ready) begin
               cap[no] = out_data; cap_sop[no] = out_sop; cap_eop[no] = out_eop;
               cap_cyc[no] = cyc_g;
               no++;
            end
         end else begin
            held = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      if (cyc >= 8000) chk("timeout_outputs", no, total_out);
   endtask

   task automatic idle_cycles(input int n);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_cw(input int base);
      int bad, nz, mb;
      mb = (base / N) * K;
      bad = 0;
      for (int i = 0; i < K; i++) if (cap[base + i] != msg[mb + i]) bad++;
      chk("message_passthrough", bad, 0);
      bad = 0;
      for (int i = 0; i < N; i++) begin
         if (cap_sop[base + i] != (i == 0)) bad++;
         if (cap_eop[base + i] != (i == N - 1)) bad++;
      end
      chk("sop_eop_framing", bad, 0);
      nz = 0;
      for (int j = 1; j <= NP; j++) if (synd(base, j) != 8'h00) nz++;
      chk("nonzero_syndromes", nz, 0);
   endtask

   initial begin
      logic [7:0] sum_roots;
      int bad, nz;
      vecs[0] = '{0, 8'h00, 100, 100, 1'b1, 8'h00, 1'b0};
      vecs[1] = '{1, 8'h01, 100, 100, 1'b1, 8'h2D, 1'b0};
      vecs[2] = '{1, 8'h02, 100, 100, 1'b1, 8'h5A, 1'b0};
      vecs[3] = '{2, 8'h00, 100, 100, 1'b0, 8'h00, 1'b0};
      vecs[4] = '{2, 8'h00, 50,  70,  1'b0, 8'h00, 1'b1};
      for (int i = 0; i < K; i++) rnd[i] = 8'($urandom_range(0, 255));
      sum_roots = 8'h00;
      for (int j = 1; j <= NP; j++) sum_roots = sum_roots ^ gf_pow(j);

      // Reset state
      #12;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_sop_eop", {out_sop, out_eop}, 0);
      chk("reset_busy", busy, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      idle_cycles(2);
      chk("idle_in_ready", in_ready, 1);

      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < K; i++)
            msg[i] = (vecs[v].kind == 2) ? rnd[i] :
                     (vecs[v].kind == 1 && i == K - 1) ? vecs[v].val : 8'h00;
         run_cw(vecs[v].rp, vecs[v].vp, 1, -1);
         check_cw(0);
         chk("stall_data_stable", stall_bad, 0);
         if (vecs[v].kind == 0) begin
            bad = 0;
            for (int i = 0; i < N; i++) if (cap[i] != 8'h00) bad++;
            chk("zero_codeword", bad, 0);
         end
         if (vecs[v].chk_last) chk("last_parity_symbol", cap[N-1], vecs[v].exp_last);
         if (vecs[v].kind == 1 && vecs[v].val == 8'h01) chk("g31_sum_of_roots", cap[K], sum_roots);
         if (vecs[v].rp == 100 && vecs[v].vp == 100)
            chk("first_parity_latency", cap_cyc[K] - cap_cyc[K-1], 1);
         if (vecs[v].kind == 2 && vecs[v].rp == 100)
            for (int i = 0; i < N; i++) gold[i] = cap[i];
         if (vecs[v].cmp_gold) begin
            bad = 0;
            for (int i = 0; i < N; i++) if (cap[i] != gold[i]) bad++;
            chk("stalled_vs_golden", bad, 0);
         end
         if (vecs[v].kind == 2) begin
            cap[100] = cap[100] ^ 8'h5A;
            nz = 0;
            for (int j = 1; j <= NP; j++) if (synd(0, j) != 8'h00) nz++;
            chk("flipped_symbol_detected", nz > 0, 1);
         end
         idle_cycles(3);
      end

      // Back-to-back codewords with continuous input
      for (int i = 0; i < K; i++) begin
         msg[i]     = rnd[i];
         msg[K + i] = 8'(i * 7 + 3);
      end
      run_cw(100, 100, 2, -1);
      check_cw(0);
      check_cw(N);
      chk("b2b_sop_after_eop", cap_cyc[N] - cap_cyc[N-1], 1);
      chk("b2b_throughput", cap_cyc[2*N-1] - cap_cyc[0], 2*N - 1);
      idle_cycles(3);

      // Reset at parity symbol 10, then a fresh codeword
      for (int i = 0; i < K; i++) msg[i] = 8'(255 - i);
      run_cw(100, 100, 1, K + 10);
      chk("busy_in_parity", busy, 1);
      reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (out_valid || busy || out_sop || out_eop || out_data != 8'h00) bad++;
      end
      chk("outputs_cleared_in_reset", bad, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      idle_cycles(1);
      for (int i = 0; i < K; i++) msg[i] = rnd[i];
      run_cw(100, 100, 1, -1);
      check_cw(0);
      bad = 0;
      for (int i = 0; i < N; i++) if (cap[i] != gold[i]) bad++;
      chk("post_reset_vs_golden", bad, 0);
      idle_cycles(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
